// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, sink FSM states and flit field positions.
package noc_pkg;

    localparam int unsigned FLIT_TYPE_BITS = 2;

    localparam logic [FLIT_TYPE_BITS-1:0] FLIT_BODY   = 2'b00;
    localparam logic [FLIT_TYPE_BITS-1:0] FLIT_HEAD   = 2'b01;
    localparam logic [FLIT_TYPE_BITS-1:0] FLIT_TAIL   = 2'b10;
    localparam logic [FLIT_TYPE_BITS-1:0] FLIT_SINGLE = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } sink_state_e;

    // Type field occupies the top two bits of the flit.
    function automatic int unsigned flit_type_msb(input int unsigned flit_bits);
        return flit_bits - 1;
    endfunction

    function automatic int unsigned flit_type_lsb(input int unsigned flit_bits);
        return flit_bits - FLIT_TYPE_BITS;
    endfunction

    // Destination sits directly below the type field.
    function automatic int unsigned flit_dest_msb(input int unsigned flit_bits);
        return flit_bits - FLIT_TYPE_BITS - 1;
    endfunction

    function automatic int unsigned flit_dest_lsb(input int unsigned flit_bits,
                                                  input int unsigned addr_bits);
        return flit_bits - FLIT_TYPE_BITS - addr_bits;
    endfunction

    // Timestamp occupies the low bits.
    function automatic int unsigned flit_ts_msb(input int unsigned ts_bits);
        return ts_bits - 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating accumulator: adds an unsigned increment when enabled, sticks at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned INC_BITS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [INC_BITS-1:0] inc,
    output logic [WIDTH-1:0]    count
);

    localparam int unsigned SUM_BITS = ((WIDTH > INC_BITS) ? WIDTH : INC_BITS) + 1;
    localparam logic [SUM_BITS-1:0] MAX_VAL = SUM_BITS'({WIDTH{1'b1}});

    logic [SUM_BITS-1:0] sum;

    assign sum = SUM_BITS'(count) + SUM_BITS'(inc);

    // Accumulate with clamp at the largest representable count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= (sum > MAX_VAL) ? '1 : WIDTH'(sum);
        end
    end

endmodule

// File: rtl/traffic_sink.sv
// NoC ejection-port sink: checks framing/destination, measures latency, tracks drain.
module traffic_sink
    import noc_pkg::*;
#(
    parameter int unsigned FLIT_BITS    = 32,
    parameter int unsigned ADDR_BITS    = 4,
    parameter int unsigned MY_ADDR      = 0,
    parameter int unsigned TS_BITS      = 16,
    parameter int unsigned CNT_BITS     = 32,
    parameter int unsigned DRAIN_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 send,
    input  logic                 stall,
    input  logic [FLIT_BITS-1:0] in_flit,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [CNT_BITS-1:0]  pkt_count,
    output logic [CNT_BITS-1:0]  flit_count,
    output logic [CNT_BITS-1:0]  err_count,
    output logic [CNT_BITS-1:0]  lat_sum,
    output logic [TS_BITS-1:0]   lat_max,
    output logic                 drained
);

    localparam int unsigned TYPE_MSB  = flit_type_msb(FLIT_BITS);
    localparam int unsigned TYPE_LSB  = flit_type_lsb(FLIT_BITS);
    localparam int unsigned DEST_MSB  = flit_dest_msb(FLIT_BITS);
    localparam int unsigned DEST_LSB  = flit_dest_lsb(FLIT_BITS, ADDR_BITS);
    localparam int unsigned TS_MSB    = flit_ts_msb(TS_BITS);
    localparam int unsigned IDLE_BITS = $clog2(DRAIN_CYCLES + 1);
    localparam logic [ADDR_BITS-1:0] OWN_ADDR  = ADDR_BITS'(MY_ADDR);
    localparam logic [IDLE_BITS-1:0] IDLE_LAST = IDLE_BITS'(DRAIN_CYCLES - 1);
    localparam logic [IDLE_BITS-1:0] IDLE_FULL = IDLE_BITS'(DRAIN_CYCLES);

    sink_state_e state_q;
    logic [TS_BITS-1:0]   now_q;
    logic [TS_BITS-1:0]   ts_q;
    logic [IDLE_BITS-1:0] idle_cnt;

    logic                 accept;
    logic [1:0]           flit_type;
    logic [ADDR_BITS-1:0] flit_dest;
    logic [TS_BITS-1:0]   flit_ts;
    logic                 frame_err_c;
    logic                 addr_err_c;
    logic                 complete_c;
    logic [TS_BITS-1:0]   done_ts_c;
    logic [TS_BITS-1:0]   latency_c;
    logic [1:0]           err_inc_c;
    logic                 quiet_c;
    logic                 unused_flit_bits;

    assign in_ready  = !stall && !reset;
    assign accept    = in_valid && in_ready;
    assign flit_type = in_flit[TYPE_MSB:TYPE_LSB];
    assign flit_dest = in_flit[DEST_MSB:DEST_LSB];
    assign flit_ts   = in_flit[TS_MSB:0];
    assign unused_flit_bits = ^in_flit;

    // Classify the accepted flit: framing/address errors and packet completion.
    always_comb begin
        frame_err_c = 1'b0;
        addr_err_c  = 1'b0;
        complete_c  = 1'b0;
        done_ts_c   = ts_q;
        if (accept) begin
            case (flit_type)
                FLIT_HEAD: begin
                    frame_err_c = (state_q == ST_IN_PKT);
                    addr_err_c  = (flit_dest != OWN_ADDR);
                end
                FLIT_SINGLE: begin
                    frame_err_c = (state_q == ST_IN_PKT);
                    addr_err_c  = (flit_dest != OWN_ADDR);
                    complete_c  = 1'b1;
                    done_ts_c   = flit_ts;
                end
                FLIT_TAIL: begin
                    frame_err_c = (state_q == ST_IDLE);
                    complete_c  = (state_q == ST_IN_PKT);
                end
                default: begin
                    frame_err_c = (state_q == ST_IDLE);
                end
            endcase
        end
    end

    assign latency_c = now_q - done_ts_c;
    assign err_inc_c = {1'b0, frame_err_c} + {1'b0, addr_err_c};
    assign quiet_c   = !send && !accept && (state_q == ST_IDLE);

    // Packet FSM, timestamp latch, cycle counter, latency peak and drain detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ts_q     <= '0;
            now_q    <= '0;
            lat_max  <= '0;
            idle_cnt <= '0;
            drained  <= 1'b0;
        end else begin
            now_q <= now_q + TS_BITS'(1);
            if (accept) begin
                case (flit_type)
                    FLIT_HEAD: begin
                        state_q <= ST_IN_PKT;
                        ts_q    <= flit_ts;
                    end
                    FLIT_SINGLE: state_q <= ST_IDLE;
                    FLIT_TAIL:   state_q <= ST_IDLE;
                    default:     state_q <= state_q;
                endcase
            end
            if (complete_c && (latency_c > lat_max)) begin
                lat_max <= latency_c;
            end
            if (!quiet_c) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_FULL) begin
                idle_cnt <= idle_cnt + IDLE_BITS'(1);
            end
            if (quiet_c && (idle_cnt == IDLE_LAST)) begin
                drained <= 1'b1;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_BITS), .INC_BITS(1)) u_pkt_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (complete_c),
        .inc   (1'b1),
        .count (pkt_count)
    );

    sat_counter #(.WIDTH(CNT_BITS), .INC_BITS(1)) u_flit_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .inc   (1'b1),
        .count (flit_count)
    );

    sat_counter #(.WIDTH(CNT_BITS), .INC_BITS(2)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (frame_err_c || addr_err_c),
        .inc   (err_inc_c),
        .count (err_count)
    );

    sat_counter #(.WIDTH(CNT_BITS), .INC_BITS(TS_BITS)) u_lat_sum (
        .clk   (clk),
        .reset (reset),
        .en    (complete_c),
        .inc   (latency_c),
        .count (lat_sum)
    );

endmodule

// File: tb/tb_traffic_sink.sv
// Self-checking bench for traffic_sink: directed table, corner sequences, random vs model.
module tb_traffic_sink;

    localparam int unsigned FB    = 32;
    localparam int unsigned AB    = 4;
    localparam int unsigned TSB   = 16;
    localparam int unsigned DRAIN = 8;
    localparam int unsigned MY    = 3;
    localparam int          TS_MASK = 65535;

    localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;

    logic clk = 1'b0;
    logic reset, send, stall, in_valid;
    logic [FB-1:0] in_flit;

    logic        in_ready, drained;
    logic [31:0] pkt_count, flit_count, err_count, lat_sum;
    logic [15:0] lat_max;
    logic        in_ready4, drained4;
    logic [3:0]  pkt_count4, flit_count4, err_count4, lat_sum4;
    logic [15:0] lat_max4;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit     m_open;
    int     m_ts, m_now;
    longint m_pkt, m_flit, m_err, m_sum, m_max;
    int     m_quiet;
    bit     m_drained;

    always #5 clk = ~clk;

    traffic_sink #(.FLIT_BITS(FB), .ADDR_BITS(AB), .MY_ADDR(MY), .TS_BITS(TSB),
                   .CNT_BITS(32), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .reset(reset), .send(send), .stall(stall),
        .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
        .pkt_count(pkt_count), .flit_count(flit_count), .err_count(err_count),
        .lat_sum(lat_sum), .lat_max(lat_max), .drained(drained));

    traffic_sink #(.FLIT_BITS(FB), .ADDR_BITS(AB), .MY_ADDR(MY), .TS_BITS(TSB),
                   .CNT_BITS(4), .DRAIN_CYCLES(DRAIN)) dut4 (
        .clk(clk), .reset(reset), .send(send), .stall(stall),
        .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready4),
        .pkt_count(pkt_count4), .flit_count(flit_count4), .err_count(err_count4),
        .lat_sum(lat_sum4), .lat_max(lat_max4), .drained(drained4));

    function automatic logic [FB-1:0] mk(input logic [1:0] typ, input int dest, input int ts);
        logic [FB-1:0] f;
        f = '0;
        f[31:30] = typ;
        f[29:26] = 4'(dest);
        f[15:0]  = 16'(ts);
        return f;
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_complete(input int ts);
        int lat;
        lat = (m_now - ts) & TS_MASK;
        m_pkt++;
        m_sum += lat;
        if (lat > m_max) m_max = lat;
    endtask

    // Behavioural model of one rising edge, using the inputs present at that edge.
    task automatic model_edge();
        bit acc;
        logic [1:0] typ;
        int dest, ts, errs;
        bit was_open;
        if (reset) begin
            m_open = 0; m_ts = 0; m_now = 0; m_pkt = 0; m_flit = 0; m_err = 0;
            m_sum = 0; m_max = 0; m_quiet = 0; m_drained = 0;
            return;
        end
        acc = in_valid && !stall;
        was_open = m_open;
        if (acc) begin
            typ  = in_flit[31:30];
            dest = int'(in_flit[29:26]);
            ts   = int'(in_flit[15:0]);
            errs = 0;
            if (typ == T_HEAD || typ == T_SINGLE) begin
                if (m_open) errs++;
                if (dest != MY) errs++;
                if (typ == T_HEAD) begin
                    m_open = 1; m_ts = ts;
                end else begin
                    m_open = 0; model_complete(ts);
                end
            end else if (!m_open) begin
                errs++;
            end else if (typ == T_TAIL) begin
                model_complete(m_ts);
                m_open = 0;
            end
            m_flit++;
            m_err += errs;
        end
        if (send || acc || was_open) m_quiet = 0;
        else m_quiet++;
        if (m_quiet >= DRAIN) m_drained = 1;
        m_now = (m_now + 1) & TS_MASK;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model();
        chk("rnd_in_ready",  64'(in_ready),    64'(!stall && !reset));
        chk("rnd_pkt",       64'(pkt_count),   64'(sat(m_pkt, 32)));
        chk("rnd_flit",      64'(flit_count),  64'(sat(m_flit, 32)));
        chk("rnd_err",       64'(err_count),   64'(sat(m_err, 32)));
        chk("rnd_lat_sum",   64'(lat_sum),     64'(sat(m_sum, 32)));
        chk("rnd_lat_max",   64'(lat_max),     64'(m_max));
        chk("rnd_drained",   64'(drained),     64'(m_drained));
        chk("rnd4_pkt",      64'(pkt_count4),  64'(sat(m_pkt, 4)));
        chk("rnd4_flit",     64'(flit_count4), 64'(sat(m_flit, 4)));
        chk("rnd4_err",      64'(err_count4),  64'(sat(m_err, 4)));
        chk("rnd4_lat_sum",  64'(lat_sum4),    64'(sat(m_sum, 4)));
    endtask

    task automatic do_reset(input int n);
        reset = 1; in_valid = 0; stall = 0;
        for (int i = 0; i < n; i++) tick();
        reset = 0;
    endtask

    typedef struct {
        logic [1:0] typ;
        int dest;
        int ts_off;
        bit valid;
        bit stl;
        int e_pkt, e_flit, e_err, e_sum, e_max;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int base_flit;
        bit reached;

        reset = 1; send = 1; stall = 0; in_valid = 0; in_flit = '0;

        // Directed framing/address/latency table (cumulative expectations).
        vecs[0]  = '{T_SINGLE, 3, 5, 1, 0, 1, 1, 0, 5, 5};
        vecs[1]  = '{T_HEAD,   3, 3, 1, 0, 1, 2, 0, 5, 5};
        vecs[2]  = '{T_BODY,   3, 0, 1, 0, 1, 3, 0, 5, 5};
        vecs[3]  = '{T_TAIL,   3, 0, 1, 0, 2, 4, 0, 10, 5};
        vecs[4]  = '{T_TAIL,   3, 0, 1, 0, 2, 5, 1, 10, 5};
        vecs[5]  = '{T_HEAD,   3, 1, 1, 0, 2, 6, 1, 10, 5};
        vecs[6]  = '{T_HEAD,   3, 2, 1, 0, 2, 7, 2, 10, 5};
        vecs[7]  = '{T_TAIL,   3, 0, 1, 0, 3, 8, 2, 13, 5};
        vecs[8]  = '{T_SINGLE, 4, 7, 1, 0, 4, 9, 3, 20, 7};
        vecs[9]  = '{T_HEAD,   4, 0, 1, 0, 4, 10, 4, 20, 7};
        vecs[10] = '{T_SINGLE, 4, 1, 1, 0, 5, 11, 6, 21, 7};
        vecs[11] = '{T_BODY,   3, 0, 0, 0, 5, 11, 6, 21, 7};
        vecs[12] = '{T_BODY,   3, 0, 1, 1, 5, 11, 6, 21, 7};

        do_reset(3);
        reset = 1;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'(0));
        chk("reset_pkt", 64'(pkt_count), 64'(0));
        chk("reset_flit", 64'(flit_count), 64'(0));
        chk("reset_err", 64'(err_count), 64'(0));
        chk("reset_lat_sum", 64'(lat_sum), 64'(0));
        chk("reset_lat_max", 64'(lat_max), 64'(0));
        chk("reset_drained", 64'(drained), 64'(0));
        reset = 0;

        foreach (vecs[i]) begin
            in_valid = vecs[i].valid;
            stall    = vecs[i].stl;
            in_flit  = mk(vecs[i].typ, vecs[i].dest, m_now - vecs[i].ts_off);
            tick();
            in_valid = 0; stall = 0;
            chk($sformatf("tbl%0d_pkt", i),     64'(pkt_count),  64'(vecs[i].e_pkt));
            chk($sformatf("tbl%0d_flit", i),    64'(flit_count), 64'(vecs[i].e_flit));
            chk($sformatf("tbl%0d_err", i),     64'(err_count),  64'(vecs[i].e_err));
            chk($sformatf("tbl%0d_lat_sum", i), 64'(lat_sum),    64'(vecs[i].e_sum));
            chk($sformatf("tbl%0d_lat_max", i), 64'(lat_max),    64'(vecs[i].e_max));
        end

        // Backpressure: held flit must not be taken while stalled.
        in_flit = mk(T_SINGLE, MY, 0);
        in_valid = 1; stall = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_flit_hold", 64'(flit_count), 64'(11));
            chk("bp_pkt_hold", 64'(pkt_count), 64'(5));
        end
        stall = 0;
        #1;
        chk("bp_ready_release", 64'(in_ready), 64'(1));
        tick();
        in_valid = 0;
        chk("bp_flit_after", 64'(flit_count), 64'(12));
        chk("bp_pkt_after", 64'(pkt_count), 64'(6));
        tick();
        chk("bp_flit_once", 64'(flit_count), 64'(12));

        // Latency across the timestamp wrap.
        do_reset(2);
        reached = 0;
        for (int i = 0; i < 100 && !reached; i++) begin
            if (m_now == 16'h0010) reached = 1;
            else tick();
        end
        chk("wrap_reached_now", 64'(reached), 64'(1));
        in_flit = mk(T_SINGLE, MY, 16'hFFF0);
        in_valid = 1;
        tick();
        in_valid = 0;
        chk("wrap_lat_sum", 64'(lat_sum), 64'(32));
        chk("wrap_lat_max", 64'(lat_max), 64'(32));
        chk("wrap_pkt", 64'(pkt_count), 64'(1));

        // Saturation with 4-bit counters.
        do_reset(2);
        for (int i = 0; i < 17; i++) begin
            in_flit = mk(T_SINGLE, MY, m_now - 1);
            in_valid = 1;
            tick();
        end
        in_valid = 0;
        chk("sat4_pkt", 64'(pkt_count4), 64'(15));
        chk("sat4_flit", 64'(flit_count4), 64'(15));
        chk("sat4_lat_sum", 64'(lat_sum4), 64'(15));
        chk("sat4_err", 64'(err_count4), 64'(0));
        chk("sat32_pkt", 64'(pkt_count), 64'(17));
        chk("sat32_lat_sum", 64'(lat_sum), 64'(17));

        // Drain timing.
        send = 1;
        do_reset(2);
        for (int i = 0; i < 5; i++) tick();
        chk("drain_pre", 64'(drained), 64'(0));
        send = 0;
        for (int i = 1; i <= int'(DRAIN); i++) begin
            tick();
            chk($sformatf("drain_edge%0d", i), 64'(drained), 64'(i == int'(DRAIN)));
        end
        send = 1;
        in_flit = mk(T_SINGLE, MY, m_now);
        in_valid = 1;
        tick();
        in_valid = 0;
        chk("drain_sticky", 64'(drained), 64'(1));
        chk("drain_late_pkt", 64'(pkt_count), 64'(1));

        // Reset in the middle of a packet.
        in_flit = mk(T_HEAD, MY, m_now);
        in_valid = 1;
        tick();
        in_valid = 0;
        base_flit = int'(flit_count);
        chk("midpkt_head_taken", 64'(base_flit), 64'(2));
        do_reset(1);
        chk("midpkt_rst_pkt", 64'(pkt_count), 64'(0));
        chk("midpkt_rst_flit", 64'(flit_count), 64'(0));
        chk("midpkt_rst_err", 64'(err_count), 64'(0));
        chk("midpkt_rst_drained", 64'(drained), 64'(0));
        chk("midpkt_rst_lat_max", 64'(lat_max), 64'(0));
        in_flit = mk(T_TAIL, MY, 0);
        in_valid = 1;
        tick();
        in_valid = 0;
        chk("midpkt_tail_err", 64'(err_count), 64'(1));
        chk("midpkt_tail_pkt", 64'(pkt_count), 64'(0));
        chk("midpkt_tail_flit", 64'(flit_count), 64'(1));

        // Randomised traffic against the reference model.
        send = 1;
        do_reset(2);
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] typ;
            int dest, ts;
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 149) == 0) send = !send;
            stall = ($urandom_range(0, 3) == 0);
            in_valid = send ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
            typ  = 2'($urandom_range(0, 3));
            dest = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'(MY);
            ts   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                                : (m_now - int'($urandom_range(0, 40)));
            in_flit = mk(typ, dest, ts);
            in_flit[25:16] = 10'($urandom);
            tick();
            check_model();
        end
        reset = 0; in_valid = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
